mmio_bus_router: RTL
====================

# mmio_bus_router

Parametrised memory-mapped request router between the CPU's start/busy memory port and N slave ports (SDRAM controller, SPI flash reader, VRAM, ROM, I/O). It decodes the address against per-slave base/size windows and forwards a one-cycle request carrying the window-relative offset. It waits for the selected slave's acknowledge and returns read data to the CPU. Beyond fixed-window decoding, it adds a per-transaction watchdog, an error response for unmapped addresses and timeouts, and a re-trigger guard on the held-high start.

## Interface
- N_SLAVES, 4, number of slave ports (1..16)
- ADDR_W, 27, CPU word-address width
- DATA_W, 32, data width
- TIMEOUT, 1024, cycles in WAIT before error completion (≥2)
- REGION_BASE, {27'hC00420, 27'hC00000, 27'h800000, 27'h000000}, packed N_SLAVES*ADDR_W; slave 0 in LSBs
- REGION_SIZE, {27'h2002, 27'h420, 27'h400000, 27'h800000}, packed N_SLAVES*ADDR_W; window size in words
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- address  in  ADDR_W  CPU address
- data  in  DATA_W  CPU write data
- we  in  1  write enable
- start  in  1  request; held high by CPU until it sees busy low
- busy  out  1  transaction in progress
- q  out  DATA_W  read data, valid when busy falls
- err  out  1  last transaction unmapped or timed out
- s_req  out  N_SLAVES  one-hot, one-cycle request pulse
- s_addr  out  ADDR_W  address minus REGION_BASE of selected slave
- s_wdata  out  DATA_W  latched write data
- s_we  out  1  latched write enable
- s_ack  in  N_SLAVES  per-slave completion pulse
- s_rdata  in  N_SLAVES*DATA_W  per-slave read data, sampled with ack

## Operation
- Reset values: busy 0, q 0, err 0, s_req 0, s_addr 0, s_wdata 0, s_we 0, state IDLE, watchdog 0.
- Decode: slave i hits if address ≥ BASE[i] and (address − BASE[i]) < SIZE[i], compared at ADDR_W bits with no wrap. Overlapping windows resolve to the lowest index.
- States: IDLE, WAIT, ERR, DONE.
- IDLE, start=1, hit on i:
  - set busy, s_req[i], s_addr, s_wdata, s_we; clear watchdog; go WAIT.
- IDLE, start=1, no hit: set busy; go ERR.
- WAIT:
  - s_req drops after one cycle; s_addr/s_wdata/s_we stay stable until DONE, then return to 0.
  - s_ack[sel]=1: q ← s_rdata[sel] (also on writes), err ← 0, busy ← 0; go DONE.
  - Otherwise watchdog increments. At watchdog = TIMEOUT−1: q ← 0, err ← 1, busy ← 0; go DONE.
  - Ack and timeout on the same edge: ack wins.
  - Acks from non-selected slaves are ignored.
- ERR: q ← 0, err ← 1, busy ← 0; go DONE.
- DONE:
  - go IDLE when start=0.
  - a start still high is never re-accepted; this prevents double issue.
- Late acks after a timeout are ignored.
- err holds until the next completion.
- reset mid-transaction returns to IDLE with all outputs at reset values. An outstanding slave ack is then dropped.

## Timing
- E0 = edge sampling start in IDLE; busy is high after E0. The CPU ignores busy during the cycle it raises start.
- Mapped, slave acks combinationally while s_req is high: completion at E1; busy high for 1 cycle.
- Slave acks registered one cycle after req: completion at E2.
- Unmapped: completion at E1; err=1 after E1.
- Timeout: completion at E0+TIMEOUT.
- Minimum issue interval: completion edge, ≥1 edge in DONE with start=0, then the next E0.

## Structure
- Package mmio_bus_router_pkg:
  - state enum
  - default base/size constants per named region (SDRAM, FLASH, VRAM32, VRAM8, ROM, IO)
  - function region_slice(i) for packed-vector indexing
- Sub-module mmio_region_decoder: purely combinational. Inputs are address, BASE and SIZE; outputs are hit, one-hot sel, binary index and offset. Instantiated once; separately unit-tested.

## Test plan
- Default params, read 0x000010, slave 0 acks 2 cycles after req with 0xDEADBEEF -> s_req=4'b0001, s_addr=0x10, q=0xDEADBEEF, err=0, busy high 3 cycles.
- Write 0xC00425 data 0x5A, slave 3 acks combinationally -> s_req=4'b1000, s_addr=0x5, s_we=1, s_wdata=0x5A, busy high 1 cycle.
- Read 0xC02500 (unmapped) -> no s_req, busy high 1 cycle, q=0, err=1; next mapped access clears err.
- TIMEOUT=16, slave 1 never acks on 0x800000 -> busy falls 16 cycles after E0 with err=1; an ack injected at cycle 20 changes nothing.
- start held high 5 cycles after completion -> exactly one s_req pulse; new request accepted only after start low.
- reset asserted in WAIT at cycle 3 -> next cycle all outputs 0, state IDLE; subsequent read to slave 2 completes normally.

Source files
------------

// File: rtl/mmio_bus_router_pkg.sv
// Shared definitions for the MMIO request router.
//   state_t          : router transaction state
//   *_BASE / *_SIZE  : named address windows of the default memory map (word addresses)
//   DEF_REGION_*     : packed default windows for the four default slave ports
//   region_slice()   : low bit of element idx in a packed vector of width-bit elements
package mmio_bus_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR,
    ST_DONE
  } state_t;

  localparam int DEF_ADDR_W   = 27;
  localparam int DEF_N_SLAVES = 4;

  localparam logic [DEF_ADDR_W-1:0] SDRAM_BASE  = 27'h000000;
  localparam logic [DEF_ADDR_W-1:0] SDRAM_SIZE  = 27'h800000;
  localparam logic [DEF_ADDR_W-1:0] FLASH_BASE  = 27'h800000;
  localparam logic [DEF_ADDR_W-1:0] FLASH_SIZE  = 27'h400000;
  localparam logic [DEF_ADDR_W-1:0] VRAM32_BASE = 27'hC00000;
  localparam logic [DEF_ADDR_W-1:0] VRAM32_SIZE = 27'h000400;
  localparam logic [DEF_ADDR_W-1:0] VRAM8_BASE  = 27'hC00400;
  localparam logic [DEF_ADDR_W-1:0] VRAM8_SIZE  = 27'h000020;
  localparam logic [DEF_ADDR_W-1:0] ROM_BASE    = 27'hC00420;
  localparam logic [DEF_ADDR_W-1:0] ROM_SIZE    = 27'h002000;
  localparam logic [DEF_ADDR_W-1:0] IO_BASE     = 27'hC02420;
  localparam logic [DEF_ADDR_W-1:0] IO_SIZE     = 27'h000002;

  // VRAM32+VRAM8 share one slave port, as do ROM+IO; the windows are contiguous.
  localparam logic [DEF_ADDR_W-1:0] VRAM_SIZE   = VRAM32_SIZE + VRAM8_SIZE;
  localparam logic [DEF_ADDR_W-1:0] ROMIO_SIZE  = ROM_SIZE + IO_SIZE;

  localparam logic [DEF_N_SLAVES*DEF_ADDR_W-1:0] DEF_REGION_BASE =
    {ROM_BASE, VRAM32_BASE, FLASH_BASE, SDRAM_BASE};
  localparam logic [DEF_N_SLAVES*DEF_ADDR_W-1:0] DEF_REGION_SIZE =
    {ROMIO_SIZE, VRAM_SIZE, FLASH_SIZE, SDRAM_SIZE};

  function automatic int region_slice(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mmio_region_decoder.sv
// Combinational address decoder: matches an address against N base/size windows.
//   address : CPU word address
//   base    : packed window bases, slave 0 in LSBs
//   size    : packed window sizes in words, slave 0 in LSBs
//   hit     : address falls in at least one window
//   sel     : one-hot winning slave (lowest index on overlap)
//   idx     : binary index of the winning slave
//   offset  : address minus the winning window's base
module mmio_region_decoder
  import mmio_bus_router_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 27,
  parameter int IDX_W    = 2
) (
  input  logic [ADDR_W-1:0]          address,
  input  logic [N_SLAVES*ADDR_W-1:0] base,
  input  logic [N_SLAVES*ADDR_W-1:0] size,
  output logic                       hit,
  output logic [N_SLAVES-1:0]        sel,
  output logic [IDX_W-1:0]           idx,
  output logic [ADDR_W-1:0]          offset
);

  logic [N_SLAVES-1:0] in_win;
  logic [ADDR_W-1:0]   diff [N_SLAVES];

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_win
    logic [ADDR_W-1:0] win_base;
    logic [ADDR_W-1:0] win_size;
    assign win_base  = base[region_slice(g, ADDR_W) +: ADDR_W];
    assign win_size  = size[region_slice(g, ADDR_W) +: ADDR_W];
    assign diff[g]   = address - win_base;
    // The lower-bound test keeps the difference from wrapping into a false hit.
    assign in_win[g] = (address >= win_base) && (diff[g] < win_size);
  end

  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise paths without a hit infer latches.
    hit    = 1'b0;
    sel    = '0;
    idx    = '0;
    offset = '0;
    // Scan downwards so the lowest matching index is written last and wins.
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (in_win[i]) begin
        hit    = 1'b1;
        sel    = '0;
        sel[i] = 1'b1;
        idx    = IDX_W'(i);
        offset = diff[i];
      end
    end
  end

endmodule

// File: rtl/mmio_bus_router.sv
// Routes CPU start/busy memory requests to one of N slave ports by address window.
//   clk, reset        : clock, synchronous active-high reset
//   address/data/we   : CPU request, sampled when start is seen in IDLE
//   start             : CPU request, held high until busy is seen low
//   busy              : transaction in progress
//   q, err            : read data / error flag of the last completion
//   s_req             : one-hot single-cycle request pulse to the selected slave
//   s_addr            : window-relative address, held until completion
//   s_wdata, s_we     : latched write data / write enable, held until completion
//   s_ack, s_rdata    : per-slave completion pulse and read data
// Unmapped addresses and watchdog expiry complete with err=1 and q=0.
module mmio_bus_router
  import mmio_bus_router_pkg::*;
#(
  parameter int N_SLAVES = DEF_N_SLAVES,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 1024,
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_SIZE = DEF_REGION_SIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data,
  input  logic                       we,
  input  logic                       start,
  output logic                       busy,
  output logic [DATA_W-1:0]          q,
  output logic                       err,
  output logic [N_SLAVES-1:0]        s_req,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic                       s_we,
  input  logic [N_SLAVES-1:0]        s_ack,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t            state;
  logic [IDX_W-1:0]  sel_q;
  logic [WD_W-1:0]   watchdog;

  logic                dec_hit;
  logic [N_SLAVES-1:0] dec_sel;
  logic [IDX_W-1:0]    dec_idx;
  logic [ADDR_W-1:0]   dec_offset;

  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;

  mmio_region_decoder #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W)
  ) u_decoder (
    .address (address),
    .base    (REGION_BASE),
    .size    (REGION_SIZE),
    .hit     (dec_hit),
    .sel     (dec_sel),
    .idx     (dec_idx),
    .offset  (dec_offset)
  );

  // Only the slave latched at issue can complete the transaction.
  assign sel_ack   = s_ack[sel_q];
  assign sel_rdata = s_rdata[region_slice(int'(sel_q), DATA_W) +: DATA_W];

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      q        <= '0;
      err      <= 1'b0;
      s_req    <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_we     <= 1'b0;
      sel_q    <= '0;
      watchdog <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (dec_hit) begin
              s_req    <= dec_sel;
              s_addr   <= dec_offset;
              s_wdata  <= data;
              s_we     <= we;
              sel_q    <= dec_idx;
              watchdog <= '0;
              state    <= ST_WAIT;
            end else begin
              state <= ST_ERR;
            end
          end
        end

        ST_WAIT: begin
          s_req <= '0;
          // Ack is tested first so it wins over a watchdog expiring on the same edge.
          if (sel_ack || (watchdog == WD_LAST)) begin
            q       <= sel_ack ? sel_rdata : '0;
            err     <= !sel_ack;
            busy    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_we    <= 1'b0;
            state   <= ST_DONE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        ST_ERR: begin
          q     <= '0;
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end

        ST_DONE: begin
          // A start still held from the finished transaction must drop before re-issue.
          if (!start) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
